// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT frame sequencer: default sizes, FSM state type
// and the FFT input word packing.
package fft_seq_pkg;

  localparam int DEF_FFT_SIZE  = 1024;
  localparam int DEF_LOG2_SIZE = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_OUT = 2'd2
  } seq_state_e;

  // FFT input word: real part in [31:16], imaginary part in [15:0]
  function automatic logic [31:0] pack_fft_data(input logic [15:0] re, input logic [15:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/fft_frame_sequencer.sv
// Gates an audio sample stream into the FFT one frame at a time and waits for the
// filtered half-spectrum frame before admitting the next one.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no frame in flight; waits for enable
// LOAD     | samples pass straight through to the FFT until the last beat
// WAIT_OUT | counts filtered bins until bin_last or timeout
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int FFT_SIZE    = DEF_FFT_SIZE,
  parameter int LOG2_SIZE   = DEF_LOG2_SIZE,
  parameter int SAMPLE_W    = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       err_clr,
  input  logic signed [SAMPLE_W-1:0] sample_data,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic [31:0]                fft_data,
  output logic                       fft_valid,
  output logic                       fft_last,
  input  logic                       fft_ready,
  input  logic                       bin_valid,
  input  logic                       bin_last,
  output logic                       busy,
  output logic                       frame_done,
  output logic [15:0]                frame_count,
  output logic                       err_len,
  output logic                       err_timeout
);

  localparam int WAIT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [LOG2_SIZE-1:0] LAST_IDX  = LOG2_SIZE'(FFT_SIZE - 1);
  localparam logic [LOG2_SIZE-1:0] HALF_LAST = LOG2_SIZE'(FFT_SIZE / 2 - 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  seq_state_e            state, state_nxt;
  logic [LOG2_SIZE-1:0]  in_cnt;
  logic [LOG2_SIZE-1:0]  out_cnt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  beat;
  logic                  bin_end;
  logic                  timeout;
  logic                  len_bad;

  assign busy = (state != IDLE);
  assign beat = fft_valid & sample_ready;

  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    fft_valid    = 1'b0;
    fft_last     = 1'b0;
    fft_data     = '0;
    bin_end      = 1'b0;
    timeout      = 1'b0;
    len_bad      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = LOAD;
      end
      LOAD: begin
        sample_ready = fft_ready;
        fft_valid    = sample_valid;
        fft_data     = pack_fft_data(16'(sample_data), 16'h0000);
        fft_last     = (in_cnt == LAST_IDX);
        // enable is not consulted here, so a started frame always completes
        if (sample_valid && fft_ready && fft_last) state_nxt = WAIT_OUT;
      end
      WAIT_OUT: begin
        bin_end = bin_valid & bin_last;
        timeout = ~bin_end & (wait_cnt == WAIT_LAST);
        // short frame at bin_last, or a beat that pushes the count past half size
        len_bad = bin_valid & (bin_last ? (out_cnt != HALF_LAST) : (out_cnt >= HALF_LAST));
        if (bin_end)      state_nxt = enable ? LOAD : IDLE;
        else if (timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      wait_cnt    <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= bin_end;
      if (bin_end) frame_count <= frame_count + 16'd1;

      if (state_nxt != state) begin
        in_cnt   <= '0;
        out_cnt  <= '0;
        wait_cnt <= '0;
      end else if (state == LOAD) begin
        if (beat) in_cnt <= in_cnt + LOG2_SIZE'(1);
      end else if (state == WAIT_OUT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
        // saturate so an overlong frame cannot wrap back to a legal count
        if (bin_valid && (out_cnt != '1)) out_cnt <= out_cnt + LOG2_SIZE'(1);
      end

      if (len_bad)      err_len <= 1'b1;
      else if (err_clr) err_len <= 1'b0;

      if (timeout)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer with a 16-point frame and 64-cycle timeout.
module tb_fft_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        err_clr;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] fft_data;
  logic        fft_valid;
  logic        fft_last;
  logic        fft_ready;
  logic        bin_valid;
  logic        bin_last;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        err_len;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  int exp_count;
  logic exp_err_len;
  logic exp_err_to;

  always #5 clk = ~clk;

  fft_frame_sequencer #(
    .FFT_SIZE(16), .LOG2_SIZE(4), .SAMPLE_W(16), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .fft_data(fft_data), .fft_valid(fft_valid), .fft_last(fft_last), .fft_ready(fft_ready),
    .bin_valid(bin_valid), .bin_last(bin_last), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .err_len(err_len), .err_timeout(err_timeout)
  );

  typedef struct {
    logic        v;
    logic        r;
    logic [15:0] d;
    logic        ev;
    logic        er;
    logic        el;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_count"}, 32'(frame_count), 32'(exp_count[15:0]));
    chk({tag, "_err_len"}, 32'(err_len), 32'(exp_err_len));
    chk({tag, "_err_to"}, 32'(err_timeout), 32'(exp_err_to));
  endtask

  // Pushes stop_after samples into the FFT with random stalls; checks every transfer.
  task automatic send_frame(input int vpct, input int rpct, input int stop_after,
                            input int en_drop_at, input bit fix_first, input logic [15:0] first_val);
    logic [15:0] cur;
    int k;
    int cyc;
    cur = fix_first ? first_val : 16'($urandom);
    k = 0;
    cyc = 0;
    while (k < stop_after && cyc < 600) begin
      sample_valid = ($urandom_range(0, 99) < vpct);
      fft_ready    = ($urandom_range(0, 99) < rpct);
      sample_data  = cur;
      bin_valid    = $urandom_range(0, 1) == 1;
      bin_last     = $urandom_range(0, 1) == 1;
      #1;
      chk("no_done_in_load", 32'(frame_done), 32'd0);
      if (fft_valid && sample_ready) begin
        chk("xfer_data", fft_data, {cur, 16'h0000});
        chk("xfer_last", 32'(fft_last), 32'(k == 15));
        k++;
        cur = 16'($urandom);
        if (k == en_drop_at) enable = 1'b0;
      end
      tick();
      cyc++;
    end
    if (k < stop_after) chk("frame_xfer_bound", 32'(k), 32'(stop_after));
    sample_valid = 1'b0;
    bin_valid    = 1'b0;
    bin_last     = 1'b0;
  endtask

  task automatic send_bins(input int nb, input bit gaps, input bit clr_on_last);
    for (int b = 1; b <= nb; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bin_valid = 1'b0; bin_last = 1'b0; sample_valid = 1'b1;
          #1;
          chk("wait_ready_gap", 32'(sample_ready), 32'd0);
          tick();
        end
      end
      bin_valid = 1'b1;
      bin_last  = (b == nb);
      err_clr   = clr_on_last && (b == nb);
      sample_valid = 1'b1;
      #1;
      chk("wait_ready", 32'(sample_ready), 32'd0);
      chk("wait_fft_valid", 32'(fft_valid), 32'd0);
      tick();
    end
    bin_valid = 1'b0; bin_last = 1'b0; err_clr = 1'b0; sample_valid = 1'b0;
    exp_count++;
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("frame_count_bin", 32'(frame_count), 32'(exp_count[15:0]));
    tick();
    chk("frame_done_low", 32'(frame_done), 32'd0);
  endtask

  task automatic wait_timeout();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!err_timeout && k < 200);
    chk("timeout_cycles", 32'(k), 32'd64);
    chk("timeout_done", 32'(frame_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b1; err_clr = 1'b0;
    sample_data = 16'h1234; sample_valid = 1'b1; fft_ready = 1'b1;
    bin_valid = 1'b0; bin_last = 1'b0;
    exp_count = 0; exp_err_len = 1'b0; exp_err_to = 1'b0;

    // LOAD frame with stalls and sign-extension patterns
    tbl[0] = '{1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000};
    tbl[1] = '{1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 32'h0001_0000};
    tbl[2] = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 32'h0001_0000};
    tbl[3] = '{1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 32'h0002_0000};
    tbl[4] = '{1'b1, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 32'h0002_0000};
    tbl[5] = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 32'hFFFF_0000};
    tbl[6] = '{1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 32'h8000_0000};
    tbl[7] = '{1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h7FFF_0000};
    tbl[8] = '{1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 32'h1234_0000};
    tbl[9] = '{1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 32'h1234_0000};
    for (int j = 0; j < 8; j++) begin
      tbl[10+j] = '{1'b1, 1'b1, 16'(16'h0100 + j), 1'b1, 1'b1, 1'b0, {16'(16'h0100 + j), 16'h0000}};
    end
    tbl[18] = '{1'b1, 1'b0, 16'h00AA, 1'b1, 1'b0, 1'b1, 32'h00AA_0000};
    tbl[19] = '{1'b1, 1'b1, 16'h00AA, 1'b1, 1'b1, 1'b1, 32'h00AA_0000};

    // reset holds every output low regardless of inputs
    repeat (3) tick();
    chk("rst_sample_ready", 32'(sample_ready), 32'd0);
    chk("rst_fft_valid", 32'(fft_valid), 32'd0);
    chk("rst_fft_last", 32'(fft_last), 32'd0);
    chk("rst_fft_data", fft_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk_flags("rst");

    // 1/2: table-driven LOAD frame, then 8 bins
    rst = 1'b0; sample_valid = 1'b0; enable = 1'b1;
    tick();
    chk("load_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      sample_valid = tbl[i].v;
      fft_ready    = tbl[i].r;
      sample_data  = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(fft_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), 32'(sample_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_last", i), 32'(fft_last), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_data", i), fft_data, tbl[i].ed);
      tick();
    end
    sample_valid = 1'b0;
    send_bins(8, 1'b0, 1'b0);
    chk_flags("t1");

    // 3: short output frame, err_clr on the same cycle loses to the new error
    send_frame(100, 100, 16, -1, 1'b0, 16'h0);
    send_bins(6, 1'b0, 1'b1);
    exp_err_len = 1'b1;
    chk_flags("t3");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err_len = 1'b0;
    chk_flags("t3_clr");

    // 4: no bins -> timeout 64 cycles after WAIT_OUT entry
    send_frame(80, 70, 16, -1, 1'b0, 16'h0);
    enable = 1'b0;
    wait_timeout();
    exp_err_to = 1'b1;
    chk("t4_busy", 32'(busy), 32'd0);
    chk_flags("t4");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err_to = 1'b0;
    chk_flags("t4_clr");

    // bin_last on the timeout cycle wins
    enable = 1'b1;
    send_frame(90, 90, 16, -1, 1'b0, 16'h0);
    for (int c = 0; c < 64; c++) begin
      bin_valid = (c < 7) || (c == 63);
      bin_last  = (c == 63);
      tick();
    end
    bin_valid = 1'b0; bin_last = 1'b0;
    exp_count++;
    chk("race_done", 32'(frame_done), 32'd1);
    chk_flags("race");
    tick();

    // 5: enable dropped mid-frame still completes, then IDLE
    send_frame(100, 100, 16, 5, 1'b0, 16'h0);
    send_bins(8, 1'b0, 1'b0);
    chk("t5_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      bin_valid = 1'b1; bin_last = 1'b1;
      tick();
      chk("idle_bins_ignored", 32'(frame_done), 32'd0);
    end
    bin_valid = 1'b0; bin_last = 1'b0;
    chk_flags("t5");

    // 6: reset mid-LOAD, next frame restarts from sample 0
    enable = 1'b1;
    send_frame(100, 100, 9, -1, 1'b0, 16'h0);
    rst = 1'b1; sample_valid = 1'b1; fft_ready = 1'b1;
    tick();
    exp_count = 0; exp_err_len = 1'b0; exp_err_to = 1'b0;
    chk("t6_sample_ready", 32'(sample_ready), 32'd0);
    chk("t6_fft_valid", 32'(fft_valid), 32'd0);
    chk("t6_fft_data", fft_data, 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk_flags("t6");
    rst = 1'b0; sample_valid = 1'b0;
    send_frame(100, 100, 16, -1, 1'b1, 16'hFFFF);
    send_bins(8, 1'b0, 1'b0);
    chk_flags("t6_after");

    // randomized frames checked against frame-level expectations
    for (int f = 0; f < 10; f++) begin
      int nb;
      int r;
      enable = 1'b1;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      exp_err_len = 1'b0; exp_err_to = 1'b0;
      send_frame($urandom_range(40, 100), $urandom_range(40, 100), 16, -1, 1'b0, 16'h0);
      r = $urandom_range(0, 5);
      nb = (r == 0) ? 0 : (r == 1) ? 6 : (r == 2) ? 10 : 8;
      if (nb == 0) begin
        wait_timeout();
        exp_err_to = 1'b1;
      end else begin
        send_bins(nb, 1'b1, 1'b0);
        exp_err_len = (nb != 8);
      end
      chk_flags($sformatf("rnd%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
